iob_axi_mem_responder: RTL and testbench
========================================

Name: iob_axi_mem_responder

Overview:
- AXI4 slave (responder) that serves burst reads and writes from an AXI master, such as the team's stream-to-AXI DMA engine, into a local 2-port RAM.
- Used in subsystem simulation and on-chip scratch-memory builds in place of external DDR.
- Write and read channels are independent: one FSM each, concurrent operation, full one-beat-per-cycle throughput.

Parameters:
- AXI_ADDR_W, 24: byte address width.
- AXI_DATA_W, 32: data width; must be a power of 2 and >= 8.
- AXI_LEN_W, 8: burst length field width.
- AXI_ID_W, 1: transaction ID width.
- MEM_ADDR_W, 14: word address width of the backing RAM.

Ports:
- clk_i, in, 1: clock.
- cke_i, in, 1: clock enable. All state holds when low.
- arst_i, in, 1: asynchronous active-high reset.
- rst_i, in, 1: synchronous soft reset.
- axi_aw{id,addr,len,size,burst,lock,cache,prot,qos}_i, in, AXI widths: write address channel payload.
- axi_awvalid_i, in, 1 / axi_awready_o, out, 1: write address handshake.
- axi_wdata_i, in, AXI_DATA_W: write data.
- axi_wstrb_i, in, AXI_DATA_W/8: write byte strobes.
- axi_wlast_i, in, 1: last write beat.
- axi_wvalid_i, in, 1 / axi_wready_o, out, 1: write data handshake.
- axi_bid_o, out, AXI_ID_W: write response ID.
- axi_bresp_o, out, 2: write response code.
- axi_bvalid_o, out, 1 / axi_bready_i, in, 1: write response handshake.
- axi_ar{id,addr,len,size,burst,lock,cache,prot,qos}_i, in, AXI widths: read address channel payload.
- axi_arvalid_i, in, 1 / axi_arready_o, out, 1: read address handshake.
- axi_rid_o, out, AXI_ID_W: read data ID.
- axi_rdata_o, out, AXI_DATA_W: read data.
- axi_rresp_o, out, 2: read response code.
- axi_rlast_o, out, 1: last read beat.
- axi_rvalid_o, out, 1 / axi_rready_i, in, 1: read data handshake.
- ext_mem_clk_o, out, 1: RAM clock, tied to clk_i.
- ext_mem_w_en_o, out, AXI_DATA_W/8: per-byte RAM write enable.
- ext_mem_w_addr_o, out, MEM_ADDR_W: RAM write word address.
- ext_mem_w_data_o, out, AXI_DATA_W: RAM write data.
- ext_mem_r_en_o, out, 1: RAM read enable.
- ext_mem_r_addr_o, out, MEM_ADDR_W: RAM read word address.
- ext_mem_r_data_i, in, AXI_DATA_W: RAM read data. Synchronous RAM, 1-cycle latency, output holds when r_en is low.

Behaviour:
- Reset (arst_i or rst_i):
  - Both FSMs go to IDLE.
  - All valid/ready outputs are 0, bresp/rresp are 0, ID and address registers are 0.
  - rst_i mid-burst aborts the burst. No B or R response is issued for the aborted transaction.
- Address handling:
  - Word address = addr[MEM_ADDR_W+log2(AXI_DATA_W/8)-1 : log2(AXI_DATA_W/8)].
  - Upper address bits are ignored, so accesses wrap modulo the RAM size.
  - Every burst is treated as INCR with full-width beats.
  - The word address increments per beat and wraps at 2^MEM_ADDR_W.
  - size/burst/lock/cache/prot/qos are ignored.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch id, word address and len; beat counter := 0.
  - W_DATA: wready=1. Each W handshake drives ext_mem_w_en_o=wstrb for one cycle, with current address and data, then increments address and counter.
  - W_DATA exits after the beat where counter==len.
  - bresp=OKAY(00) if wlast was asserted exactly on that beat. Otherwise SLVERR(10); early wlast is ignored.
  - W_RESP: bvalid=1, bid=latched id. Held until bready, then W_IDLE.
  - AW latency: awready low from the cycle after acceptance until B completes.
- Read FSM R_IDLE -> R_BURST -> R_IDLE:
  - R_IDLE: arready=1. On AR handshake, latch id, address and len; issue counter := 0; sent counter := 0.
  - In R_BURST, a RAM read issues (r_en=1) when beats remain to issue AND (rvalid=0 OR rready=1).
  - rvalid is registered: set the cycle after an issue, cleared on handshake with no new issue.
  - rdata_o is ext_mem_r_data_i, passed combinationally.
  - First rvalid appears 2 cycles after the AR handshake. Sustained throughput is 1 beat/cycle under continuous rready.
  - rlast=1 when sent counter==len while rvalid. rresp=OKAY always.
  - On the last beat's handshake, return to R_IDLE, giving 1 idle cycle before the next arready.
- Backpressure: rready low freezes r_en, so the RAM output and rdata stay stable. Data is never dropped.
- Simultaneous write and read to the same word in the same cycle: the read returns the old data (RAM read-first). No ordering is guaranteed between channels.
- len=0 is a single beat. len=255 gives 256 beats; the counters are AXI_LEN_W+1 bits wide.

Decomposition:
- Shared package (iob_axi_mem_responder_pkg.vh) holds:
  - AXI response codes OKAY=2'b00 and SLVERR=2'b10.
  - FSM state encodings.
  - Byte-offset width macro log2(AXI_DATA_W/8).
- The read FSM plus rvalid pipeline is a natural sub-module: iob_axi_mem_rd_ctrl. The write path stays inline.
- RAM is external (iob_ram_2p instantiated by the integrator).

Test Plan:
- Write AW addr=0x100, len=3, data 0xA0..A3, strobes 0xF, wlast on beat 3 -> RAM words 0x40..0x43 written; one B with bresp=00 and bid matching awid.
- Read AR addr=0x100, len=3, rready held 1 -> rvalid 2 cycles after AR; 4 consecutive beats 0xA0..A3; rlast only on beat 3.
- Same read with rready toggling 1,0,0,1... -> rdata stable while stalled; sequence exact; exactly 4 handshakes.
- Write len=1 with wlast on beat 0 -> both beats written; bresp=10.
- Write wstrb=0x3 data 0xDEADBEEF onto word holding 0x11223344 -> read back 0x1122BEEF.
- Assert rst_i during beat 2 of a len=7 read -> rvalid=0 next cycle; arready=1; a new read completes correctly.

Source files
------------

// File: rtl/iob_axi_mem_responder_pkg.sv
// Shared definitions for the AXI4 memory responder.
// Holds the AXI response codes, the write/read FSM state encodings and a
// helper that derives the byte-offset width from the data bus width.
package iob_axi_mem_responder_pkg;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Write FSM
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Read FSM
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_BURST = 1'b1;

  // Number of low address bits that select a byte within one data word.
  function automatic int byte_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/iob_axi_mem_rd_ctrl.sv
// Read-channel controller of the AXI memory responder.
// Accepts one AR request at a time, issues one RAM read per beat and keeps a
// registered rvalid that tracks the 1-cycle RAM latency. A new RAM read is
// only issued when the beat currently on the R channel is being taken (or no
// beat is pending), so the RAM output -- and therefore rdata -- holds while
// the master stalls.
// Ports:
//   clk_i, cke_i, arst_i, rst_i : clock, clock enable, async/sync resets
//   arid, ar_word_addr, arlen   : AR payload (word address already extracted)
//   arvalid / arready           : AR handshake
//   rid, rlast                  : R sideband
//   rvalid / rready             : R handshake
//   r_en, r_addr                : RAM read port control
module iob_axi_mem_rd_ctrl
  import iob_axi_mem_responder_pkg::*;
#(
  parameter int ID_W       = 1,
  parameter int LEN_W      = 8,
  parameter int MEM_ADDR_W = 14
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_i,
  input  logic                  rst_i,
  input  logic [ID_W-1:0]       arid,
  input  logic [MEM_ADDR_W-1:0] ar_word_addr,
  input  logic [LEN_W-1:0]      arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_W-1:0]       rid,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic                  r_en,
  output logic [MEM_ADDR_W-1:0] r_addr
);

  logic [0:0]            state;
  logic                  arready_q;
  logic                  rvalid_q;
  logic [ID_W-1:0]       id_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]      len_q;
  // One bit wider than len so that len=max still counts len+1 beats.
  logic [LEN_W:0]        issue_cnt;
  logic [LEN_W:0]        sent_cnt;

  logic issue_left;
  logic issue;
  logic handshake;
  logic last_sent;

  assign issue_left = issue_cnt <= {1'b0, len_q};
  assign handshake  = rvalid_q && rready;
  assign last_sent  = sent_cnt == {1'b0, len_q};
  // Gated by cke: the RAM runs on the raw clock, so a read issued while the
  // controller is frozen would overwrite the beat still waiting on R.
  assign issue      = cke_i && (state == R_BURST) && issue_left &&
                      (!rvalid_q || rready);

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = id_q;
  assign rlast   = rvalid_q && last_sent;
  assign r_en    = issue;
  assign r_addr  = addr_q;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state     <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      sent_cnt  <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        state     <= R_IDLE;
        arready_q <= 1'b0;
        rvalid_q  <= 1'b0;
        id_q      <= '0;
        addr_q    <= '0;
        len_q     <= '0;
        issue_cnt <= '0;
        sent_cnt  <= '0;
      end else begin
        case (state)
          R_IDLE: begin
            if (arready_q && arvalid) begin
              arready_q <= 1'b0;
              id_q      <= arid;
              addr_q    <= ar_word_addr;
              len_q     <= arlen;
              issue_cnt <= '0;
              sent_cnt  <= '0;
              state     <= R_BURST;
            end else begin
              // Registered ready: leaves one idle cycle after each burst.
              arready_q <= 1'b1;
            end
          end
          R_BURST: begin
            if (issue) begin
              addr_q    <= addr_q + 1'b1;
              issue_cnt <= issue_cnt + 1'b1;
              rvalid_q  <= 1'b1;
            end else if (handshake) begin
              rvalid_q  <= 1'b0;
            end
            if (handshake) begin
              sent_cnt <= sent_cnt + 1'b1;
              if (last_sent) state <= R_IDLE;
            end
          end
          default: state <= R_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/iob_axi_mem_responder.sv
// AXI4 slave that serves INCR bursts from an external 2-port RAM.
// Write and read channels run independently and concurrently at one beat per
// cycle. Address bits above the RAM size are ignored, so accesses wrap.
// Ports:
//   clk_i, cke_i, arst_i, rst_i   : clock, clock enable, async/sync resets
//   axi_aw*, axi_w*, axi_b*       : AXI4 write address / data / response
//   axi_ar*, axi_r*               : AXI4 read address / data
//   ext_mem_*                     : 2-port RAM (sync read, 1-cycle latency)
module iob_axi_mem_responder
  import iob_axi_mem_responder_pkg::*;
#(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int MEM_ADDR_W = 14
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_i,
  input  logic                    rst_i,
  // write address
  input  logic [AXI_ID_W-1:0]     axi_awid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic [2:0]              axi_awsize_i,
  input  logic [1:0]              axi_awburst_i,
  input  logic                    axi_awlock_i,
  input  logic [3:0]              axi_awcache_i,
  input  logic [2:0]              axi_awprot_i,
  input  logic [3:0]              axi_awqos_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  // write data
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  // write response
  output logic [AXI_ID_W-1:0]     axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  // read address
  input  logic [AXI_ID_W-1:0]     axi_arid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic [2:0]              axi_arsize_i,
  input  logic [1:0]              axi_arburst_i,
  input  logic                    axi_arlock_i,
  input  logic [3:0]              axi_arcache_i,
  input  logic [2:0]              axi_arprot_i,
  input  logic [3:0]              axi_arqos_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  // read data
  output logic [AXI_ID_W-1:0]     axi_rid_o,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i,
  // external RAM
  output logic                    ext_mem_clk_o,
  output logic [AXI_DATA_W/8-1:0] ext_mem_w_en_o,
  output logic [MEM_ADDR_W-1:0]   ext_mem_w_addr_o,
  output logic [AXI_DATA_W-1:0]   ext_mem_w_data_o,
  output logic                    ext_mem_r_en_o,
  output logic [MEM_ADDR_W-1:0]   ext_mem_r_addr_o,
  input  logic [AXI_DATA_W-1:0]   ext_mem_r_data_i
);

  localparam int OFF_W = byte_off_w(AXI_DATA_W);

  // Burst type/size and attribute fields are not used: every burst is INCR
  // with full-width beats. Address bits outside the word index are dropped.
  logic unused_inputs;
  assign unused_inputs = ^{axi_awaddr_i, axi_awsize_i, axi_awburst_i,
                           axi_awlock_i, axi_awcache_i, axi_awprot_i,
                           axi_awqos_i, axi_araddr_i, axi_arsize_i,
                           axi_arburst_i, axi_arlock_i, axi_arcache_i,
                           axi_arprot_i, axi_arqos_i};

  assign ext_mem_clk_o = clk_i;

  // ---------------------------------------------------------------- write
  logic [1:0]            w_state;
  logic                  awready_q;
  logic [AXI_ID_W-1:0]   w_id_q;
  logic [MEM_ADDR_W-1:0] w_addr_q;
  logic [AXI_LEN_W-1:0]  w_len_q;
  logic [AXI_LEN_W:0]    w_cnt_q;
  logic [1:0]            bresp_q;
  logic                  w_hs;

  assign w_hs = (w_state == W_DATA) && axi_wvalid_i;

  assign axi_awready_o    = awready_q;
  assign axi_wready_o     = (w_state == W_DATA);
  assign axi_bvalid_o     = (w_state == W_RESP);
  assign axi_bid_o        = w_id_q;
  assign axi_bresp_o      = bresp_q;
  assign ext_mem_w_addr_o = w_addr_q;
  assign ext_mem_w_data_o = axi_wdata_i;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ext_mem_w_en_o = '0;
    if (w_hs && cke_i) ext_mem_w_en_o = axi_wstrb_i;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      bresp_q   <= AXI_RESP_OKAY;
    end else if (cke_i) begin
      if (rst_i) begin
        w_state   <= W_IDLE;
        awready_q <= 1'b0;
        w_id_q    <= '0;
        w_addr_q  <= '0;
        w_len_q   <= '0;
        w_cnt_q   <= '0;
        bresp_q   <= AXI_RESP_OKAY;
      end else begin
        case (w_state)
          W_IDLE: begin
            if (awready_q && axi_awvalid_i) begin
              awready_q <= 1'b0;
              w_id_q    <= axi_awid_i;
              w_addr_q  <= axi_awaddr_i[MEM_ADDR_W+OFF_W-1:OFF_W];
              w_len_q   <= axi_awlen_i;
              w_cnt_q   <= '0;
              w_state   <= W_DATA;
            end else begin
              awready_q <= 1'b1;
            end
          end
          W_DATA: begin
            if (w_hs) begin
              w_addr_q <= w_addr_q + 1'b1;
              w_cnt_q  <= w_cnt_q + 1'b1;
              if (w_cnt_q == {1'b0, w_len_q}) begin
                // Only a wlast on the final counted beat is a clean burst;
                // an early wlast is ignored and reported here.
                bresp_q <= axi_wlast_i ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                w_state <= W_RESP;
              end
            end
          end
          W_RESP: begin
            if (axi_bready_i) w_state <= W_IDLE;
          end
          default: w_state <= W_IDLE;
        endcase
      end
    end
  end

  // ----------------------------------------------------------------- read
  assign axi_rdata_o = ext_mem_r_data_i;
  assign axi_rresp_o = AXI_RESP_OKAY;

  iob_axi_mem_rd_ctrl #(
    .ID_W       (AXI_ID_W),
    .LEN_W      (AXI_LEN_W),
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_rd_ctrl (
    .clk_i        (clk_i),
    .cke_i        (cke_i),
    .arst_i       (arst_i),
    .rst_i        (rst_i),
    .arid         (axi_arid_i),
    .ar_word_addr (axi_araddr_i[MEM_ADDR_W+OFF_W-1:OFF_W]),
    .arlen        (axi_arlen_i),
    .arvalid      (axi_arvalid_i),
    .arready      (axi_arready_o),
    .rid          (axi_rid_o),
    .rlast        (axi_rlast_o),
    .rvalid       (axi_rvalid_o),
    .rready       (axi_rready_i),
    .r_en         (ext_mem_r_en_o),
    .r_addr       (ext_mem_r_addr_o)
  );

endmodule

// File: tb/tb_iob_axi_mem_responder.sv
// Directed bench for iob_axi_mem_responder with a behavioural read-first
// 2-port RAM attached to the external memory port.
module tb_iob_axi_mem_responder;

  logic        clk = 1'b0;
  logic        cke = 1'b1;
  logic        arst = 1'b1;
  logic        rst = 1'b0;

  logic        awid = 1'b0;
  logic [23:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic        arid = 1'b0;
  logic [23:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic        rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  logic        mem_clk;
  logic [3:0]  mem_w_en;
  logic [13:0] mem_w_addr;
  logic [31:0] mem_w_data;
  logic        mem_r_en;
  logic [13:0] mem_r_addr;
  logic [31:0] mem_r_data = '0;
  logic [31:0] mem [0:16383];

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_data [0:15];

  always #5 clk = ~clk;

  iob_axi_mem_responder dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst), .rst_i(rst),
    .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen),
    .axi_awsize_i(3'd2), .axi_awburst_i(2'd1), .axi_awlock_i(1'b0),
    .axi_awcache_i(4'd0), .axi_awprot_i(3'd0), .axi_awqos_i(4'd0),
    .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid),
    .axi_bready_i(bready),
    .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen),
    .axi_arsize_i(3'd2), .axi_arburst_i(2'd1), .axi_arlock_i(1'b0),
    .axi_arcache_i(4'd0), .axi_arprot_i(3'd0), .axi_arqos_i(4'd0),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp),
    .axi_rlast_o(rlast), .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .ext_mem_clk_o(mem_clk), .ext_mem_w_en_o(mem_w_en),
    .ext_mem_w_addr_o(mem_w_addr), .ext_mem_w_data_o(mem_w_data),
    .ext_mem_r_en_o(mem_r_en), .ext_mem_r_addr_o(mem_r_addr),
    .ext_mem_r_data_i(mem_r_data)
  );

  // Read-first synchronous RAM; output holds while r_en is low.
  always @(posedge mem_clk) begin
    if (mem_r_en) mem_r_data <= mem[mem_r_addr];
    for (int b = 0; b < 4; b++)
      if (mem_w_en[b]) mem[mem_w_addr][8*b +: 8] <= mem_w_data[8*b +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input logic [3:0] strb,
                          input int wlast_beat, input logic id,
                          input logic [1:0] exp_resp);
    int n;
    n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    check("aw_ready", awready, 1);
    awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("aw_low_after_accept", awready, 0);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = base + i; wstrb = strb; wlast = (i == wlast_beat);
      n = 0;
      while (!wready && n < 20) begin tick(); n++; end
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_valid", bvalid, 1);
    check("b_resp", bresp, exp_resp);
    check("b_id", bid, id);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("b_valid_clear", bvalid, 0);
  endtask

  task automatic do_read(input logic [23:0] addr, input logic [7:0] len,
                         input logic id, input bit toggle);
    int n, nbeats, cyc, k;
    bit stalled;
    logic [31:0] held;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    check("ar_ready", arready, 1);
    araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("r_lat_cycle1", rvalid, 0);
    tick();
    check("r_lat_cycle2", rvalid, 1);
    nbeats = 0; cyc = 0; k = 0; stalled = 1'b0; held = '0;
    while (nbeats <= int'(len) && cyc < 100) begin
      if (toggle) begin rready = pat[k % 4]; k++; end
      if (stalled) check("r_stall_stable", rdata, held);
      stalled = 1'b0;
      if (rvalid && rready) begin
        check("r_data", rdata, exp_data[nbeats]);
        check("r_last", rlast, (nbeats == int'(len)));
        check("r_id", rid, id);
        nbeats++;
      end else if (rvalid) begin
        held = rdata;
        stalled = 1'b1;
      end
      tick();
      cyc++;
    end
    check("r_beat_count", nbeats, int'(len) + 1);
    check("r_valid_after_last", rvalid, 0);
    tick();
    check("r_no_extra_beat", rvalid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nb, cyc;
    for (int i = 0; i < 16384; i++) mem[i] = 32'hC0DE0000 | i;

    // Reset state
    #1;
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    tick(); tick();
    arst = 1'b0;
    tick(); tick(); tick();
    check("idle_awready", awready, 1);
    check("idle_arready", arready, 1);

    // 4-beat write at 0x100 -> words 0x40..0x43
    do_write(24'h000100, 8'd3, 32'hA0, 4'hF, 3, 1'b1, 2'b00);
    for (int i = 0; i < 4; i++) check("mem_burst_write", mem[14'h40 + i], 32'hA0 + i);

    // Read back with continuous rready, then with stalls
    for (int i = 0; i < 4; i++) exp_data[i] = 32'hA0 + i;
    do_read(24'h000100, 8'd3, 1'b1, 1'b0);
    do_read(24'h000100, 8'd3, 1'b0, 1'b1);

    // Early wlast: both beats land, response is SLVERR
    do_write(24'h000200, 8'd1, 32'h55, 4'hF, 0, 1'b0, 2'b10);
    check("mem_early_wlast0", mem[14'h80], 32'h55);
    check("mem_early_wlast1", mem[14'h81], 32'h56);

    // Partial strobes merge with existing word
    do_write(24'h000300, 8'd0, 32'h11223344, 4'hF, 0, 1'b0, 2'b00);
    do_write(24'h000300, 8'd0, 32'hDEADBEEF, 4'h3, 0, 1'b1, 2'b00);
    check("mem_strobe", mem[14'hC0], 32'h1122BEEF);
    exp_data[0] = 32'h1122BEEF;
    do_read(24'h000300, 8'd0, 1'b0, 1'b0);

    // Word address wraps at the top of the RAM
    do_write(24'h00FFFC, 8'd1, 32'h77000000, 4'hF, 1, 1'b0, 2'b00);
    check("mem_wrap_top", mem[14'h3FFF], 32'h77000000);
    check("mem_wrap_zero", mem[14'h0000], 32'h77000001);
    exp_data[0] = 32'h77000000; exp_data[1] = 32'h77000001;
    do_read(24'h00FFFC, 8'd1, 1'b1, 1'b0);

    // Soft reset during beat 2 of an 8-beat read aborts it
    rready = 1'b1;
    nb = 0;
    while (!arready && nb < 20) begin tick(); nb++; end
    araddr = 24'h000100; arlen = 8'd7; arid = 1'b1; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    nb = 0; cyc = 0;
    while (nb < 2 && cyc < 50) begin
      if (rvalid) begin
        check("abort_pre_data", rdata, 32'hA0 + nb);
        nb++;
      end
      tick();
      cyc++;
    end
    check("abort_beat2_valid", rvalid, 1);
    rst = 1'b1; rready = 1'b0;
    tick();
    rst = 1'b0;
    check("abort_rvalid_cleared", rvalid, 0);
    check("abort_no_bvalid", bvalid, 0);
    tick();
    check("abort_arready", arready, 1);
    exp_data[0] = 32'h55; exp_data[1] = 32'h56;
    do_read(24'h000200, 8'd1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
